// File: rtl/baud_gen_frac.sv
// baud_gen_frac
//   Fractional-N baud tick generator for the UART path. A cycle counter
//   produces an oversample tick every div_int_r or div_int_r+1 cycles. The
//   extra cycle is taken when the fractional accumulator carried on the
//   previous tick, so the average period is div_int_r + div_frac_r/2^FRAC_W.
//   A bit tick is produced on every OVERSAMPLE-th oversample tick.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   enable       1 = count, 0 = hold all state with ticks forced low
//   div_load     strobe: load div_int_in/div_frac_in and restart the phase
//   div_int_in   integer divisor (cycles per os_tick), values below 2 become 2
//   div_frac_in  fractional divisor in units of 2^-FRAC_W cycle
//   sync_clr     restart the phase and keep the divisor
//   os_tick      registered 1-cycle oversample tick
//   bit_tick     registered 1-cycle bit tick, coincident with an os_tick

module baud_gen_frac #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int INT_W      = 16,
    parameter int FRAC_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              div_load,
    input  logic [INT_W-1:0]  div_int_in,
    input  logic [FRAC_W-1:0] div_frac_in,
    input  logic              sync_clr,
    output logic              os_tick,
    output logic              bit_tick
);

    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    // Reset divisor, computed in 64-bit arithmetic to avoid overflow.
    localparam longint unsigned DIV_X =
        (64'(CLOCK_FREQ) << FRAC_W) / (64'(BAUD_RATE) * 64'(OVERSAMPLE));
    localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DIV_X >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DIV_X);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [INT_W-1:0]  MIN_DIV  = INT_W'(2);

    logic [INT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              ext;
    logic [OS_W-1:0]   os_cnt;
    logic [INT_W-1:0]  div_int_r;
    logic [FRAC_W-1:0] div_frac_r;

    logic [INT_W:0]    term_val;
    logic              terminal;
    logic [FRAC_W:0]   frac_sum;
    logic              os_last;
    logic [INT_W-1:0]  div_int_sat;

    // Terminal count is div_int_r-1, stretched by one cycle when the previous
    // tick carried out of the accumulator. One extra bit keeps the compare
    // exact at the top of the divisor range.
    always_comb begin
        term_val    = {1'b0, div_int_r} - (INT_W+1)'(1) + (INT_W+1)'(ext);
        terminal    = ({1'b0, cnt} == term_val);
        frac_sum    = {1'b0, acc} + {1'b0, div_frac_r};
        os_last     = (os_cnt == OS_LAST);
        div_int_sat = (div_int_in < MIN_DIV) ? MIN_DIV : div_int_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            ext        <= 1'b0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
            div_int_r  <= DEF_INT;
            div_frac_r <= DEF_FRAC;
        end else if (div_load) begin
            div_int_r  <= div_int_sat;
            div_frac_r <= div_frac_in;
            cnt        <= '0;
            acc        <= '0;
            ext        <= 1'b0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
        end else if (sync_clr) begin
            cnt        <= '0;
            acc        <= '0;
            ext        <= 1'b0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
        end else if (!enable) begin
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
        end else if (terminal) begin
            cnt        <= '0;
            os_tick    <= 1'b1;
            // Carry out of the accumulator lengthens the next period only.
            {ext, acc} <= frac_sum;
            bit_tick   <= os_last;
            os_cnt     <= os_last ? '0 : os_cnt + OS_W'(1);
        end else begin
            cnt        <= cnt + INT_W'(1);
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_int_in = '0;
    logic [7:0]  div_frac_in = '0;
    logic        sync_clr = 1'b0;
    logic        os_tick;
    logic        bit_tick;

    int nvec = 0;
    int nmis = 0;

    baud_gen_frac dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .div_load    (div_load),
        .div_int_in  (div_int_in),
        .div_frac_in (div_frac_in),
        .sync_clr    (sync_clr),
        .os_tick     (os_tick),
        .bit_tick    (bit_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        ld;
        logic [15:0] di;
        logic [7:0]  df;
        logic        sc;
        logic        eos;
        logic        ebit;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic e, input logic l, input int di,
                       input int df, input logic s, input logic eos, input logic ebit);
        vec_t v;
        v.rst_n = r; v.en = e; v.ld = l; v.di = 16'(di); v.df = 8'(df);
        v.sc = s; v.eos = eos; v.ebit = ebit;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one edge; outputs are read 1 ns after it, inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_div(input int di, input int df);
        div_load = 1'b1; div_int_in = 16'(di); div_frac_in = 8'(df);
        step();
        div_load = 1'b0;
    endtask

    // Edges until the next os_tick, -1 if the bound expires.
    task automatic edges_to_tick(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!os_tick && n < limit);
        if (!os_tick) n = -1;
    endtask

    initial begin
        int n, k, cyc, bad;
        logic prev_os;

        // T1: reset defaults 325 + 133/256
        rst_n = 1'b0; enable = 1'b1;
        repeat (3) step();
        chk("reset_os", os_tick, 0);
        chk("reset_bit", bit_tick, 0);
        rst_n = 1'b1;
        edges_to_tick(1000, n);
        chk("t1_first_tick_edges", n, 325);
        chk("t1_first_bit", bit_tick, 0);
        // Periods 2..257 consume the carries of 256 additions: 256*325+133.
        k = 1; cyc = 0; bad = 0; prev_os = 1'b1;
        while (k < 257 && cyc < 90000) begin
            step();
            cyc++;
            if (os_tick) begin
                k++;
                if (bit_tick != (k % 16 == 0)) bad++;
                if (prev_os) bad++;
            end else if (bit_tick) begin
                bad++;
            end
            prev_os = os_tick;
        end
        chk("t1_256_periods", cyc, 83333);
        chk("t1_bit_pattern", bad, 0);

        // Table: minimum divisor, hold, load/sync priority, sync_clr, reset.
        add(0,0,0,0,0,0, 0,0);
        add(1,1,1,0,0,0, 0,0);   // load 0 -> 2
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);
        add(1,1,1,1,0,0, 0,0);   // load 1 -> 2
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);
        add(1,0,0,0,0,0, 0,0);   // hold
        add(1,0,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);
        add(1,1,1,3,128,1, 0,0); // load wins over sync_clr: 3 + 1/2
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);   // period 3
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);   // period 3
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);   // period 4
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);   // period 3, carry pending
        add(1,1,0,0,0,0, 0,0);   // below: sync_clr drops the pending carry
        add(1,1,0,0,0,1, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);   // first period after sync: 3
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);   // 3
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 0,0);
        add(1,1,0,0,0,0, 1,0);   // 4
        add(1,1,0,0,0,0, 0,0);
        add(0,1,0,0,0,0, 0,0);   // reset mid-period
        for (int i = 0; i < vt.size(); i++) begin
            rst_n = vt[i].rst_n; enable = vt[i].en; div_load = vt[i].ld;
            div_int_in = vt[i].di; div_frac_in = vt[i].df; sync_clr = vt[i].sc;
            step();
            chk($sformatf("vec%0d_os", i), os_tick, vt[i].eos);
            chk($sformatf("vec%0d_bit", i), bit_tick, vt[i].ebit);
        end
        div_load = 1'b0; sync_clr = 1'b0;

        // Defaults restored by the mid-period reset.
        rst_n = 1'b1; enable = 1'b1;
        edges_to_tick(1000, n);
        chk("t6_default_restored", n, 325);

        // T2: integer divisor 4
        load_div(4, 0);
        for (int i = 1; i <= 128; i++) begin
            step();
            chk("t2_os", os_tick, (i % 4 == 0));
            chk("t2_bit", bit_tick, (i % 64 == 0));
        end

        // T3: 4 + 1/2 -> periods 4,4,5,4,5,4,5
        load_div(4, 128);
        for (int i = 1; i <= 31; i++) begin
            step();
            chk("t3_os", os_tick, (i inside {4, 8, 13, 17, 22, 26, 31}));
            chk("t3_bit", bit_tick, 0);
        end

        // T4: hold 3 cycles mid-period
        load_div(10, 0);
        repeat (5) step();
        chk("t4_pre_hold", os_tick, 0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_os", os_tick, 0);
        end
        enable = 1'b1;
        edges_to_tick(50, n);
        chk("t4_resume_edges", n, 5);

        // T5: sync_clr restarts phase and oversample count
        load_div(10, 0);
        repeat (25) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("t5_clr_os", os_tick, 0);
        for (int i = 1; i <= 170; i++) begin
            step();
            chk("t5_os", os_tick, (i % 10 == 0));
            chk("t5_bit", bit_tick, (i == 160));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
